// File: rtl/fifo_pkg.sv
// Shared types and constants for the FIFO drain controller and its skid buffer.
package fifo_pkg;

  localparam int FIFO_WIDTH_DEF = 32;
  localparam int CNT_WIDTH_DEF  = 16;
  localparam int RD_LAT         = 1;
  localparam int BUF_DEPTH      = 2;

  typedef enum logic [1:0] {
    IDLE,
    ACTIVE,
    FLUSH
  } drain_state_e;

endpackage

// File: rtl/fifo_skid_buf.sv
// Two-entry FIFO-ordered holding buffer; head is always entry 0 and is fully registered.
module fifo_skid_buf
  import fifo_pkg::*;
#(
  parameter int WIDTH = FIFO_WIDTH_DEF
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push,
  input  logic [WIDTH-1:0] data_in,
  input  logic             pop,
  output logic [WIDTH-1:0] head,
  output logic [1:0]       count
);

  logic [WIDTH-1:0] entry_reg  [BUF_DEPTH];
  logic [WIDTH-1:0] entry_next [BUF_DEPTH];
  logic [1:0]       count_reg, count_next;
  logic             shift;
  logic [1:0]       wr_idx;

  assign shift      = pop && (count_reg != 2'd0);
  // A push lands in the first free slot after any same-cycle shift.
  assign wr_idx     = count_reg - {1'b0, shift};
  assign count_next = count_reg + {1'b0, push} - {1'b0, shift};

  for (genvar gi = 0; gi < BUF_DEPTH; gi++) begin : g_entry
    if (gi < BUF_DEPTH - 1) begin : g_shift
      assign entry_next[gi] = (push && wr_idx == 2'(gi)) ? data_in :
                              shift                      ? entry_reg[gi+1] :
                                                           entry_reg[gi];
    end else begin : g_last
      assign entry_next[gi] = (push && wr_idx == 2'(gi)) ? data_in : entry_reg[gi];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count_reg <= 2'd0;
      for (int i = 0; i < BUF_DEPTH; i++) entry_reg[i] <= '0;
    end else begin
      count_reg <= count_next;
      for (int i = 0; i < BUF_DEPTH; i++) entry_reg[i] <= entry_next[i];
    end
  end

  assign head  = entry_reg[0];
  assign count = count_reg;

endmodule

// File: rtl/fifo_drain_ctrl.sv
// Drains an upstream FIFO (1-cycle read latency) into a valid/ready stream via a 2-entry buffer.
// Optional popped-word counter port pop_cnt is built only when FIFO_DRAIN_CNT_EN is defined.
module fifo_drain_ctrl
  import fifo_pkg::*;
#(
  parameter int FIFO_WIDTH = FIFO_WIDTH_DEF,
  parameter int CNT_WIDTH  = CNT_WIDTH_DEF
) (
  input  logic                  clk,
  input  logic                  rstN,
  input  logic                  drain_en,
  input  logic                  fifo_empty,
  input  logic [FIFO_WIDTH-1:0] fifo_data_out,
  output logic                  fifo_rd_en,
  output logic                  m_valid,
  output logic [FIFO_WIDTH-1:0] m_data,
  input  logic                  m_ready,
  output logic                  busy
`ifdef FIFO_DRAIN_CNT_EN
  ,
  output logic [CNT_WIDTH-1:0]  pop_cnt
`endif
);

  drain_state_e state_reg, state_next;
  logic         inflight_reg;
  logic [1:0]   occ;
  logic         pop;
  logic [2:0]   pending_eff;

  fifo_skid_buf #(
    .WIDTH(FIFO_WIDTH)
  ) u_buf (
    .clk    (clk),
    .rst_n  (rstN),
    .push   (inflight_reg),
    .data_in(fifo_data_out),
    .pop    (pop),
    .head   (m_data),
    .count  (occ)
  );

  assign m_valid = (occ != 2'd0);
  assign pop     = m_valid && m_ready;
  assign busy    = inflight_reg || (occ != 2'd0);

  // Occupancy plus in-flight, crediting the slot a same-cycle pop frees so a full-rate stream never stalls.
  assign pending_eff = {1'b0, occ} - {2'b0, pop} + {2'b0, inflight_reg};
  assign fifo_rd_en  = drain_en && !fifo_empty && (state_reg == ACTIVE) &&
                       (pending_eff < 3'(BUF_DEPTH));

  always_ff @(posedge clk or negedge rstN) begin
    if (!rstN) begin
      state_reg    <= IDLE;
      inflight_reg <= 1'b0;
    end else begin
      state_reg    <= state_next;
      inflight_reg <= fifo_rd_en;
    end
  end

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE:    if (drain_en) state_next = ACTIVE;
      ACTIVE:  if (!drain_en) state_next = busy ? FLUSH : IDLE;
      FLUSH:   if (!inflight_reg && occ == 2'd0) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

`ifdef FIFO_DRAIN_CNT_EN
  logic [CNT_WIDTH-1:0] cnt_reg;

  always_ff @(posedge clk or negedge rstN) begin
    if (!rstN) begin
      cnt_reg <= '0;
    end else if (fifo_rd_en) begin
      cnt_reg <= cnt_reg + CNT_WIDTH'(1);
    end
  end

  assign pop_cnt = cnt_reg;
`else
  // Counter width only matters when the counter is built; keep it referenced for width sanity.
  if (CNT_WIDTH < 1) begin : g_cnt_width_unused
  end
`endif

endmodule

// File: tb/tb_fifo_drain_ctrl.sv
// Scoreboard bench for fifo_drain_ctrl: upstream FIFO model, expected words queued on push.
module tb_fifo_drain_ctrl;
  import fifo_pkg::*;

  localparam int W     = 32;
  localparam int CNT_W = 4;

  logic         clk = 1'b0;
  logic         rstN, drain_en, fifo_empty, fifo_rd_en, m_valid, m_ready, busy;
  logic [W-1:0] fifo_data_out, m_data;
`ifdef FIFO_DRAIN_CNT_EN
  logic [CNT_W-1:0] pop_cnt;
`endif

  always #5 clk = ~clk;

  fifo_drain_ctrl #(
    .FIFO_WIDTH(W),
    .CNT_WIDTH (CNT_W)
  ) dut (
    .clk          (clk),
    .rstN         (rstN),
    .drain_en     (drain_en),
    .fifo_empty   (fifo_empty),
    .fifo_data_out(fifo_data_out),
    .fifo_rd_en   (fifo_rd_en),
    .m_valid      (m_valid),
    .m_data       (m_data),
    .m_ready      (m_ready),
    .busy         (busy)
`ifdef FIFO_DRAIN_CNT_EN
    ,
    .pop_cnt      (pop_cnt)
`endif
  );

  // Upstream FIFO model: data appears one cycle after the read strobe.
  logic [W-1:0] fifo_mem [0:255];
  int           wr_ptr = 0;
  int           rd_ptr = 0;
  assign fifo_empty = (wr_ptr == rd_ptr);

  always @(posedge clk) begin
    if (fifo_rd_en) begin
      fifo_data_out <= fifo_mem[rd_ptr];
      rd_ptr        <= rd_ptr + 1;
    end
  end

  int           cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  logic [W-1:0] exp_q[$];
  int           xfer_cyc_q[$];
  int           n_xfer       = 0;
  int           rd_pulses    = 0;
  int           first_rd_cyc = -1;
  bit           rd_empty_viol = 1'b0;
  bit           hold_prev    = 1'b0;
  logic [W-1:0] hold_data;
  int           n_checks     = 0;
  int           n_pass       = 0;
  int           rel_cyc;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
  endtask

  task automatic push_word(input logic [W-1:0] w);
    fifo_mem[wr_ptr] = w;
    wr_ptr++;
    exp_q.push_back(w);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_xfers(input int target, input int budget, input string tag);
    for (int i = 0; i < budget && n_xfer < target; i++) tick();
    check(tag, 64'(n_xfer), 64'(target));
  endtask

  // Monitor: samples on the falling edge, compares each transfer against the scoreboard.
  always @(negedge clk) begin
    if (rstN) begin
      if (fifo_rd_en) begin
        rd_pulses++;
        if (first_rd_cyc < 0) first_rd_cyc = cyc;
        if (fifo_empty) rd_empty_viol = 1'b1;
      end
      if (hold_prev) begin
        check("hold_valid", 64'(m_valid), 64'd1);
        check("hold_data", 64'(m_data), 64'(hold_data));
      end
      if (m_valid && m_ready) begin
        if (exp_q.size() == 0) check("xfer_unexpected", 64'(exp_q.size()), 64'd1);
        else check("xfer_data", 64'(m_data), 64'(exp_q.pop_front()));
        n_xfer++;
        xfer_cyc_q.push_back(cyc);
      end
      hold_prev = m_valid && !m_ready;
      hold_data = m_data;
    end else begin
      hold_prev = 1'b0;
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    rstN     = 1'b0;
    drain_en = 1'b0;
    m_ready  = 1'b0;

    // Streaming: words queued and drain enabled while still in reset.
    push_word(32'h11);
    push_word(32'h22);
    push_word(32'h33);
    drain_en = 1'b1;
    m_ready  = 1'b1;
    repeat (3) tick();
    check("rst_rd_en", 64'(fifo_rd_en), 64'd0);
    check("rst_m_valid", 64'(m_valid), 64'd0);
    check("rst_m_data", 64'(m_data), 64'd0);
    check("rst_busy", 64'(busy), 64'd0);
    check("rst_state", 64'(dut.state_reg), 64'(IDLE));
`ifdef FIFO_DRAIN_CNT_EN
    check("rst_pop_cnt", 64'(pop_cnt), 64'd0);
`endif
    rel_cyc = cyc;
    rstN    = 1'b1;
    wait_xfers(3, 20, "stream_xfers");
    check("stream_busy_after", 64'(busy), 64'd0);
    check("stream_valid_after", 64'(m_valid), 64'd0);
    check("first_rd_not_early", 64'(first_rd_cyc >= rel_cyc + 1), 64'd1);
    check("stream_latency", 64'(xfer_cyc_q[0] - first_rd_cyc), 64'd2);
    check("stream_gap1", 64'(xfer_cyc_q[1] - xfer_cyc_q[0]), 64'd1);
    check("stream_gap2", 64'(xfer_cyc_q[2] - xfer_cyc_q[1]), 64'd1);
`ifdef FIFO_DRAIN_CNT_EN
    check("stream_pop_cnt", 64'(pop_cnt), 64'd3);
`endif

    // Backpressure: only two reads may be issued while the consumer stalls.
    m_ready   = 1'b0;
    rd_pulses = 0;
    for (int i = 0; i < 4; i++) push_word(32'hA0 + 32'(i));
    repeat (5) tick();
    check("bp_rd_pulses", 64'(rd_pulses), 64'd2);
    check("bp_m_valid", 64'(m_valid), 64'd1);
    check("bp_m_data", 64'(m_data), 64'hA0);
    check("bp_occupancy", 64'(dut.u_buf.count_reg), 64'd2);
    m_ready = 1'b1;
    wait_xfers(7, 20, "bp_xfers");
    check("bp_busy_after", 64'(busy), 64'd0);

    // Empty upstream: no reads, no output, stays ACTIVE.
    rd_pulses = 0;
    repeat (10) tick();
    check("empty_rd_pulses", 64'(rd_pulses), 64'd0);
    check("empty_m_valid", 64'(m_valid), 64'd0);
    check("empty_state", 64'(dut.state_reg), 64'(ACTIVE));

    // Flush: drain_en drops the cycle after the read; the in-flight word must still arrive.
    rd_pulses = 0;
    push_word(32'h5A);
    push_word(32'h5B);
    tick();
    drain_en = 1'b0;
    tick();
    check("flush_state", 64'(dut.state_reg), 64'(FLUSH));
    for (int i = 0; i < 10 && dut.state_reg != IDLE; i++) tick();
    check("flush_to_idle", 64'(dut.state_reg), 64'(IDLE));
    check("flush_xfers", 64'(n_xfer), 64'd8);
    repeat (3) tick();
    check("flush_rd_pulses", 64'(rd_pulses), 64'd1);

    // Reset with a full buffer: buffered words are dropped, next FIFO word comes out first.
    m_ready  = 1'b0;
    drain_en = 1'b1;
    for (int i = 1; i <= 4; i++) push_word(32'h60 + 32'(i));
    repeat (6) tick();
    check("mid_occupancy", 64'(dut.u_buf.count_reg), 64'd2);
    check("mid_head", 64'(m_data), 64'h5B);
    rstN = 1'b0;
    #1;
    check("mid_rst_m_valid", 64'(m_valid), 64'd0);
    check("mid_rst_busy", 64'(busy), 64'd0);
    check("mid_rst_m_data", 64'(m_data), 64'd0);
    exp_q.delete();
    for (int i = rd_ptr; i < wr_ptr; i++) exp_q.push_back(fifo_mem[i]);
    check("mid_next_word", 64'(exp_q[0]), 64'h62);
    m_ready = 1'b1;
    repeat (2) tick();
    rstN = 1'b1;
    wait_xfers(11, 20, "mid_xfers");
`ifdef FIFO_DRAIN_CNT_EN
    check("mid_pop_cnt", 64'(pop_cnt), 64'd3);
`endif

    // Wrap: 14 more pops take the 4-bit counter from 3 to 17 mod 16.
    for (int i = 0; i < 14; i++) push_word(32'h100 + 32'(i));
    wait_xfers(25, 60, "wrap_xfers");
`ifdef FIFO_DRAIN_CNT_EN
    check("wrap_pop_cnt", 64'(pop_cnt), 64'd1);
`endif
    check("wrap_busy_after", 64'(busy), 64'd0);
    check("scoreboard_empty", 64'(exp_q.size()), 64'd0);
    check("no_rd_when_empty", 64'(rd_empty_viol), 64'd0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/fifo_drain_ctrl.md
FIFO_DRAIN_CTRL -- requirements
Module: fifo_drain_ctrl

Interface
REQ-001 The block SHALL have parameter FIFO_WIDTH, default 32, meaning the data word width in bits.
REQ-002 The block SHALL have parameter CNT_WIDTH, default 16, meaning the width of the popped-word counter.
REQ-003 The block SHALL have these ports:
- clk  input  1  single clock; all logic on the rising edge.
- rstN  input  1  asynchronous, active-low reset.
- drain_en  input  1  permits new FIFO reads.
- fifo_empty  input  1  upstream FIFO empty flag.
- fifo_data_out  input  FIFO_WIDTH  upstream FIFO read data, valid one cycle after fifo_rd_en.
- fifo_rd_en  output  1  pop request to the upstream FIFO.
- m_valid  output  1  downstream data valid.
- m_data  output  FIFO_WIDTH  downstream data.
- m_ready  input  1  downstream accept.
- busy  output  1  read in flight or buffer non-empty.
- pop_cnt  output  CNT_WIDTH  popped-word count; present only under the macro in REQ-019.

Function
REQ-004 fifo_rd_en SHALL assert only when drain_en=1, fifo_empty=0, state=ACTIVE, and (buffer occupancy + in-flight reads) < 2.
REQ-005 Read latency SHALL be fixed at 1: a registered in-flight flag set by fifo_rd_en captures fifo_data_out into the buffer on the next edge.
REQ-006 The buffer SHALL hold 2 entries, be FIFO-ordered, and never overflow; a capture and an m_valid&&m_ready pop in the same cycle SHALL keep occupancy unchanged.
REQ-007 m_valid SHALL equal (occupancy != 0); m_data SHALL be the head entry, registered, with no combinational path from fifo_data_out.
REQ-008 While m_valid=1 and m_ready=0, m_data SHALL be held stable.
REQ-009 With m_ready held at 1 and the FIFO non-empty, throughput SHALL be one word per cycle after 2 cycles of startup latency (rd_en to m_valid).
REQ-010 The state machine SHALL have states IDLE, ACTIVE and FLUSH.
REQ-011 IDLE->ACTIVE SHALL occur when drain_en=1.
REQ-012 ACTIVE->FLUSH SHALL occur when drain_en=0 while a read is in flight or the buffer is non-empty; ACTIVE->IDLE SHALL occur when drain_en=0 and nothing is pending.
REQ-013 FLUSH->IDLE SHALL occur when the in-flight flag is 0 and occupancy=0; FLUSH SHALL issue no new reads but SHALL deliver all pending words.
REQ-014 busy SHALL equal in-flight OR occupancy != 0.
REQ-015 When fifo_empty=1, fifo_rd_en SHALL be 0 in that cycle, regardless of other conditions.

Reset
REQ-016 On rstN=0, the block SHALL asynchronously go to state IDLE with fifo_rd_en=0, m_valid=0, m_data=0, busy=0, pop_cnt=0, occupancy=0 and in-flight=0.
REQ-017 Reset mid-operation SHALL discard buffered and in-flight words; a read issued in the cycle before reset SHALL NOT be captured after release.
REQ-018 After rstN deasserts, the first fifo_rd_en SHALL occur no earlier than the second rising edge.

Configuration
REQ-019 With macro FIFO_DRAIN_CNT_EN defined, pop_cnt SHALL increment by 1 per cycle with fifo_rd_en=1 and wrap from 2^CNT_WIDTH-1 to 0.
REQ-020 Without FIFO_DRAIN_CNT_EN, the pop_cnt port and its counter SHALL be absent, and all other behaviour SHALL be identical.

Structure
REQ-021 Package fifo_pkg SHALL hold the FIFO_WIDTH default, CNT_WIDTH default, the drain_state_e enum (IDLE, ACTIVE, FLUSH) and the constant RD_LAT=1.
REQ-022 The 2-entry buffer SHALL be sub-module fifo_skid_buf (push/data_in, pop, head, count); the FSM, read issue and counter SHALL reside in fifo_drain_ctrl.

Verification
REQ-023 The bench SHALL cover these directed scenarios:
- Streaming: FIFO holds 0x11,0x22,0x33, m_ready=1, drain_en=1 -> m_data 0x11,0x22,0x33 on consecutive cycles; pop_cnt=3; busy falls the cycle after the last transfer.
- Backpressure: FIFO holds 4 words, m_ready=0 for 5 cycles -> exactly 2 rd_en pulses, m_data=word0 stable; on release, all 4 words arrive in order.
- Empty: fifo_empty=1 throughout, drain_en=1 -> fifo_rd_en never 1, m_valid=0, state ACTIVE.
- Flush: drain_en drops in the cycle after rd_en, m_ready=1 -> the in-flight word is delivered, state FLUSH->IDLE, no further rd_en.
- Reset mid-stream: rstN=0 with occupancy=2 -> m_valid=0 immediately; after release, the first output is the next FIFO word.
- Wrap: CNT_WIDTH=4 with the macro defined, 17 pops -> pop_cnt=1.
